dti_mem_arbiter: RTL and testbench

Two-requester memory-port arbiter that sits in front of dti_apb_adapter. It shares the adapter's single mem_* request/ack interface between instruction fetch (port 0) and load/store (port 1). When a request wins, the arbiter latches the full request, drives it downstream until the adapter acks, then routes the ack and read data back to the owner. Arbitration is round-robin, and each port has a saturating completed-transaction counter.

---
 rtl/dti_mem_arbiter_pkg.sv | 26 ++
 rtl/dti_mem_arbiter_sat_counter.sv | 32 +++
 rtl/dti_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dti_mem_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dti_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dti_mem_arbiter_pkg
// Shared encodings for the two-port memory arbiter in front of
// dti_apb_adapter.
//   - access size codes (byte / half / word)
//   - requester port indices (instruction fetch / load-store)
//   - arbiter FSM state encoding
// -----------------------------------------------------------------------------
package dti_mem_arbiter_pkg;

  // Access size encodings carried on *_data_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Requester port indices
  localparam logic PORT_IF = 1'b0;  // instruction fetch
  localparam logic PORT_LS = 1'b1;  // load/store

  // Arbiter FSM states
  typedef enum logic {
    ARB_ST_IDLE = 1'b0,
    ARB_ST_BUSY = 1'b1
  } arb_state_t;

endpackage : dti_mem_arbiter_pkg

// File: rtl/dti_mem_arbiter_sat_counter.sv
// -----------------------------------------------------------------------------
// dti_sat_counter
// Saturating up-counter with synchronous clear. Counts one per cycle while
// inc is high and holds at all-ones once reached.
// Ports:
//   clk    in   clock
//   clear  in   synchronous clear, active high, wins over inc
//   inc    in   increment enable
//   count  out  CNT_W current count
// -----------------------------------------------------------------------------
module dti_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule : dti_sat_counter

// File: rtl/dti_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dti_mem_arbiter
// Shares the single mem_* request/ack interface of dti_apb_adapter between
// instruction fetch (port 0) and load/store (port 1). A winning request is
// latched and driven downstream until the adapter acks; the ack and read
// data are then routed back to the owner only. Ties are broken round-robin;
// each port has a saturating completed-transaction counter.
//
// Optional feature macro: DTI_ARB_FIXED_PRIO_EN
//   defined   : port 1 always wins ties (INIT_PRIO ignored, no rr pointer)
//   undefined : round-robin, first tie after reset goes to INIT_PRIO
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   rN_address/data_in/size     request fields from port N (N = 0, 1)
//   rN_read_req/write_req       level requests, held until ack
//   rN_read_ack/write_ack       one-cycle completion to port N
//   rN_data_out                 read data, valid with rN_read_ack
//   rN_txn_cnt                  completed transactions, saturating
//   mem_*                       request/ack interface to the adapter
//   arb_busy                    high while a transaction is outstanding
// -----------------------------------------------------------------------------
module dti_mem_arbiter
  import dti_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int INIT_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  // port 0 : instruction fetch
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [DATA_W-1:0] r0_data_in,
  input  logic [1:0]        r0_data_size,
  input  logic              r0_read_req,
  input  logic              r0_write_req,
  output logic              r0_read_ack,
  output logic              r0_write_ack,
  output logic [DATA_W-1:0] r0_data_out,
  output logic [CNT_W-1:0]  r0_txn_cnt,
  // port 1 : load/store
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [DATA_W-1:0] r1_data_in,
  input  logic [1:0]        r1_data_size,
  input  logic              r1_read_req,
  input  logic              r1_write_req,
  output logic              r1_read_ack,
  output logic              r1_write_ack,
  output logic [DATA_W-1:0] r1_data_out,
  output logic [CNT_W-1:0]  r1_txn_cnt,
  // adapter side
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [1:0]        mem_data_size,
  output logic              mem_read_req,
  output logic              mem_write_req,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_read_ack,
  input  logic              mem_write_ack,
  output logic              arb_busy
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;

  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_size;
  logic              r_wr;
`ifndef DTI_ARB_FIXED_PRIO_EN
  logic              r_rr_ptr;
`endif

  logic              w_req0;
  logic              w_req1;
  logic              w_grant;
  logic              w_ack_in;
  logic              w_take;
  logic              w_done;
  logic [1:0]        w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt [2];

  assign w_req0   = r0_read_req | r0_write_req;
  assign w_req1   = r1_read_req | r1_write_req;
  assign w_ack_in = mem_read_ack | mem_write_ack;
  // acks outside ST_BUSY are stray and must not complete anything
  assign w_done   = (r_state == ARB_ST_BUSY) && w_ack_in;
  assign w_take   = (r_state == ARB_ST_IDLE) && (w_req0 || w_req1);

  // Tie-break selection; a lone requester always wins
  always_comb begin
    w_grant = PORT_IF;
    if (w_req0 && w_req1) begin
`ifdef DTI_ARB_FIXED_PRIO_EN
      w_grant = PORT_LS;
`else
      w_grant = r_rr_ptr;
`endif
    end else if (w_req1) begin
      w_grant = PORT_LS;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ARB_ST_IDLE: if (w_req0 || w_req1) w_state_next = ARB_ST_BUSY;
      ARB_ST_BUSY: if (w_ack_in)         w_state_next = ARB_ST_IDLE;
      default:                           w_state_next = ARB_ST_IDLE;
    endcase
  end

  // Request latch and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= PORT_IF;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_wr    <= 1'b0;
`ifndef DTI_ARB_FIXED_PRIO_EN
      r_rr_ptr <= (INIT_PRIO != 0);
`endif
    end else begin
      if (w_take) begin
        r_owner <= w_grant;
        // write_req alone decides direction, so read+write together is a write
        if (w_grant == PORT_LS) begin
          r_addr <= r1_address;
          r_data <= r1_data_in;
          r_size <= r1_data_size;
          r_wr   <= r1_write_req;
        end else begin
          r_addr <= r0_address;
          r_data <= r0_data_in;
          r_size <= r0_data_size;
          r_wr   <= r0_write_req;
        end
      end
`ifndef DTI_ARB_FIXED_PRIO_EN
      if (w_done) begin
        r_rr_ptr <= ~r_owner;
      end
`endif
    end
  end

  // FSM: outputs. The request is masked in the ack cycle so the adapter
  // returns to idle instead of seeing a stale request; the adapter's ack does
  // not depend on req, so this is not a combinational loop.
  always_comb begin
    arb_busy      = 1'b0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    r0_read_ack   = 1'b0;
    r0_write_ack  = 1'b0;
    r0_data_out   = '0;
    r1_read_ack   = 1'b0;
    r1_write_ack  = 1'b0;
    r1_data_out   = '0;
    if (r_state == ARB_ST_BUSY) begin
      arb_busy      = 1'b1;
      mem_write_req = r_wr & ~w_ack_in;
      mem_read_req  = ~r_wr & ~w_ack_in;
      if (w_ack_in) begin
        if (r_owner == PORT_LS) begin
          r1_read_ack  = mem_read_ack;
          r1_write_ack = mem_write_ack;
          r1_data_out  = mem_data_out;
        end else begin
          r0_read_ack  = mem_read_ack;
          r0_write_ack = mem_write_ack;
          r0_data_out  = mem_data_out;
        end
      end
    end
  end

  assign mem_address   = r_addr;
  assign mem_data_in   = r_data;
  assign mem_data_size = r_size;

  // Per-port completed-transaction counters
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      assign w_cnt_inc[gi] = w_done && (r_owner == gi[0]);
      dti_sat_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_cnt_inc[gi]),
        .count (w_cnt[gi])
      );
    end
  endgenerate

  assign r0_txn_cnt = w_cnt[0];
  assign r1_txn_cnt = w_cnt[1];

endmodule : dti_mem_arbiter

// File: tb/tb_dti_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dti_mem_arbiter
// Self-checking bench for dti_mem_arbiter with a small adapter responder.
// Counters are built 4 bits wide so saturation is reachable quickly.
// -----------------------------------------------------------------------------
module tb_dti_mem_arbiter;

  localparam int CNT_W     = 4;
  localparam int CNT_MAX   = 15;
  localparam int INIT_PRIO = 0;
  localparam logic [31:0] RD_KEY = 32'hA5A5_5A5A;
`ifdef DTI_ARB_FIXED_PRIO_EN
  localparam bit TB_FIXED = 1'b1;
`else
  localparam bit TB_FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [31:0] r0_address = '0, r1_address = '0;
  logic [31:0] r0_data_in = '0, r1_data_in = '0;
  logic [1:0]  r0_data_size = '0, r1_data_size = '0;
  logic        r0_read_req = 1'b0, r0_write_req = 1'b0;
  logic        r1_read_req = 1'b0, r1_write_req = 1'b0;
  logic        r0_read_ack, r0_write_ack, r1_read_ack, r1_write_ack;
  logic [31:0] r0_data_out, r1_data_out;
  logic [CNT_W-1:0] r0_txn_cnt, r1_txn_cnt;
  logic [31:0] mem_address, mem_data_in;
  logic [1:0]  mem_data_size;
  logic        mem_read_req, mem_write_req;
  logic [31:0] mem_data_out = '0;
  logic        mem_read_ack = 1'b0, mem_write_ack = 1'b0;
  logic        arb_busy;

  int n_vec = 0;
  int n_err = 0;
  bit exp_rr;

  // adapter responder controls
  int          ad_lat = 2;
  int          ad_cnt = 0;
  bit          ad_fixed = 1'b0;
  logic [31:0] ad_rdata = '0;
  bit          stray_ack = 1'b0;

  always #5 clk = ~clk;

  dti_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W), .INIT_PRIO(INIT_PRIO)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_data_in(r0_data_in), .r0_data_size(r0_data_size),
    .r0_read_req(r0_read_req), .r0_write_req(r0_write_req),
    .r0_read_ack(r0_read_ack), .r0_write_ack(r0_write_ack),
    .r0_data_out(r0_data_out), .r0_txn_cnt(r0_txn_cnt),
    .r1_address(r1_address), .r1_data_in(r1_data_in), .r1_data_size(r1_data_size),
    .r1_read_req(r1_read_req), .r1_write_req(r1_write_req),
    .r1_read_ack(r1_read_ack), .r1_write_ack(r1_write_ack),
    .r1_data_out(r1_data_out), .r1_txn_cnt(r1_txn_cnt),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_size(mem_data_size),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_data_out(mem_data_out), .mem_read_ack(mem_read_ack),
    .mem_write_ack(mem_write_ack), .arb_busy(arb_busy)
  );

  // Adapter model: acks a pending request ad_lat+1 edges after first seeing
  // it, one-cycle ack pulse. Read data is address ^ RD_KEY unless fixed.
  always @(posedge clk) begin
    if (mem_read_ack || mem_write_ack) begin
      mem_read_ack  <= 1'b0;
      mem_write_ack <= 1'b0;
      mem_data_out  <= '0;
      ad_cnt        <= 0;
    end else if (stray_ack) begin
      mem_read_ack  <= 1'b1;
      mem_data_out  <= 32'hBAD0_BAD0;
    end else if (mem_read_req || mem_write_req) begin
      if (ad_cnt >= ad_lat) begin
        mem_read_ack  <= mem_read_req;
        mem_write_ack <= mem_write_req;
        mem_data_out  <= mem_read_req ? (ad_fixed ? ad_rdata : (mem_address ^ RD_KEY)) : '0;
        ad_cnt        <= 0;
      end else begin
        ad_cnt <= ad_cnt + 1;
      end
    end else begin
      ad_cnt <= 0;
    end
  end

  task automatic drop_all();
    r0_read_req = 1'b0; r0_write_req = 1'b0;
    r1_read_req = 1'b0; r1_write_req = 1'b0;
  endtask

  task automatic do_reset();
    drop_all();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_rr = (INIT_PRIO != 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({arb_busy, mem_read_req, mem_write_req} !== 3'b000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 000", {arb_busy, mem_read_req, mem_write_req});
    end
    n_vec++;
    if ({mem_address, mem_data_in, mem_data_size} !== 66'd0) begin
      n_err++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_address, mem_data_in, mem_data_size});
    end
    n_vec++;
    if ({r0_read_ack, r0_write_ack, r1_read_ack, r1_write_ack} !== 4'b0000) begin
      n_err++; $display("FAIL reset_acks: got %b expected 0000", {r0_read_ack, r0_write_ack, r1_read_ack, r1_write_ack});
    end
    n_vec++;
    if ({r0_data_out, r1_data_out, r0_txn_cnt, r1_txn_cnt} !== '0) begin
      n_err++; $display("FAIL reset_data_cnt: got %h %h %0d %0d expected 0", r0_data_out, r1_data_out, r0_txn_cnt, r1_txn_cnt);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_single_read();
    int acks = 0;
    bit other_bad = 1'b0;
    do_reset();
    ad_fixed = 1'b1; ad_rdata = 32'hDEAD_BEEF; ad_lat = 3;
    r0_address = 32'h0000_1000; r0_data_size = 2'b10; r0_read_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({arb_busy, mem_read_req, mem_write_req, mem_address} !== {3'b110, 32'h0000_1000}) begin
      n_err++; $display("FAIL single_latency: got %b%b%b %h expected 110 00001000", arb_busy, mem_read_req, mem_write_req, mem_address);
    end
    for (int c = 0; c < 20; c++) begin
      if (r1_read_ack || r1_write_ack || r1_data_out != 0 || r0_write_ack) other_bad = 1'b1;
      if (r0_read_ack) begin
        acks++;
        n_vec++;
        if (r0_data_out !== 32'hDEAD_BEEF) begin
          n_err++; $display("FAIL single_rdata: got %h expected deadbeef", r0_data_out);
        end
        r0_read_req = 1'b0;
      end
      @(negedge clk);
    end
    n_vec++;
    if (acks != 1) begin
      n_err++; $display("FAIL single_ack_count: got %0d expected 1", acks);
    end
    n_vec++;
    if (other_bad) begin
      n_err++; $display("FAIL single_other_port: got activity expected none");
    end
    n_vec++;
    if ({r0_txn_cnt, r1_txn_cnt, arb_busy} !== {4'd1, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL single_cnt: got %0d %0d busy %b expected 1 0 busy 0", r0_txn_cnt, r1_txn_cnt, arb_busy);
    end
    ad_fixed = 1'b0;
    $display("single_read: r0 read 0x1000 acks=%0d cnt=%0d", acks, r0_txn_cnt);
  endtask

  task automatic test_simultaneous();
    bit first;
    bit ok;
    logic [31:0] exp_a;
    do_reset();
    ad_lat = 1;
    first = TB_FIXED ? 1'b1 : (INIT_PRIO != 0);
    r0_address = 32'h100; r0_data_size = 2'b10; r0_read_req = 1'b1;
    r1_address = 32'h200; r1_data_size = 2'b10; r1_read_req = 1'b1;
    for (int t = 0; t < 2; t++) begin
      exp_a = ((t == 0) ? first : ~first) ? 32'h200 : 32'h100;
      @(negedge clk);
      n_vec++;
      if ({arb_busy, mem_address} !== {1'b1, exp_a}) begin
        n_err++; $display("FAIL simul_grant%0d: got busy %b addr %h expected busy 1 addr %h", t, arb_busy, mem_address, exp_a);
      end
      ok = 1'b0;
      for (int c = 0; c < 10 && !ok; c++) begin
        if (r0_read_ack) begin ok = 1'b1; r0_read_req = 1'b0; end
        if (r1_read_ack) begin ok = 1'b1; r1_read_req = 1'b0; end
        if (!ok) @(negedge clk);
      end
      n_vec++;
      if (!ok) begin
        n_err++; $display("FAIL simul_ack%0d: got no ack expected ack", t);
      end
      @(negedge clk);  // arbiter idle cycle
    end
    n_vec++;
    if ({r0_txn_cnt, r1_txn_cnt} !== {4'd1, 4'd1}) begin
      n_err++; $display("FAIL simul_cnt: got %0d %0d expected 1 1", r0_txn_cnt, r1_txn_cnt);
    end
    drop_all();
    $display("simultaneous: first grant port %0d", first);
  endtask

  task automatic test_rw_both();
    int rd = 0, wr = 0;
    do_reset();
    ad_lat = 2;
    r0_address = 32'h3000; r0_data_in = 32'hCAFE_F00D; r0_data_size = 2'b01;
    r0_read_req = 1'b1; r0_write_req = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({mem_write_req, mem_read_req, mem_data_in} !== {2'b10, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL rw_both_dir: got w%b r%b %h expected w1 r0 cafef00d", mem_write_req, mem_read_req, mem_data_in);
    end
    for (int c = 0; c < 12; c++) begin
      if (r0_read_ack) rd++;
      if (r0_write_ack) begin wr++; r0_read_req = 1'b0; r0_write_req = 1'b0; end
      @(negedge clk);
    end
    n_vec++;
    if (rd != 0 || wr != 1) begin
      n_err++; $display("FAIL rw_both_acks: got rd %0d wr %0d expected rd 0 wr 1", rd, wr);
    end
    $display("rw_both: write acks=%0d read acks=%0d", wr, rd);
  endtask

  task automatic test_stability();
    bit got = 1'b0;
    do_reset();
    ad_lat = 5;
    r1_address = 32'h2000; r1_data_in = 32'h1234_5678; r1_data_size = 2'b10; r1_write_req = 1'b1;
    @(negedge clk);
    r1_address = $urandom; r1_data_in = $urandom; r1_data_size = 2'($urandom_range(0, 1));
    for (int c = 0; c < 20 && !got; c++) begin
      if (mem_read_ack || mem_write_ack) begin
        got = 1'b1;
        n_vec++;
        if ({mem_write_req, mem_read_req, r1_write_ack, r1_read_ack, r0_write_ack, r0_read_ack} !== 6'b001000) begin
          n_err++; $display("FAIL stab_ack_cycle: got %b expected 001000",
            {mem_write_req, mem_read_req, r1_write_ack, r1_read_ack, r0_write_ack, r0_read_ack});
        end
        r1_write_req = 1'b0;
      end else begin
        n_vec++;
        if ({mem_address, mem_data_in, mem_data_size, mem_write_req, mem_read_req} !==
            {32'h2000, 32'h1234_5678, 2'b10, 2'b10}) begin
          n_err++; $display("FAIL stab_hold: got %h %h %b w%b r%b expected 2000 12345678 10 w1 r0",
            mem_address, mem_data_in, mem_data_size, mem_write_req, mem_read_req);
        end
        r1_address = $urandom; r1_data_in = $urandom;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!got || r1_txn_cnt !== 4'd1) begin
      n_err++; $display("FAIL stab_done: got ack %b cnt %0d expected ack 1 cnt 1", got, r1_txn_cnt);
    end
    $display("stability: r1 write 0x2000 held, ack seen %b", got);
  endtask

  // Random traffic against a transaction-level model: pending request per
  // port, tie-break rule, expected busy timeline and saturating counts.
  task automatic run_traffic(input string name, input int n_txn, input bit always_req, input bit check_gap);
    bit          pend [2];
    bit          p_wr [2];
    bit          p_both [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_data [2];
    logic [1:0]  p_size [2];
    int          exp_cnt [2];
    bit          prev_busy = 1'b0, prev_ack = 1'b0, exp_busy, ad_ack, w;
    bit          owner = 1'b0;
    int          done = 0, n_grants = 0, dut_idle = 0;
    logic [3:0]  exp_acks;
    logic [31:0] exp_d [2];
    for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; exp_cnt[p] = 0; end
    ad_lat = $urandom_range(0, 3);
    for (int cyc = 0; cyc < n_txn * 30 && done < n_txn; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && (always_req || $urandom_range(0, 2) == 0)) begin
          pend[p]   = 1'b1;
          p_addr[p] = $urandom;
          p_data[p] = $urandom;
          p_size[p] = 2'($urandom_range(0, 2));
          p_wr[p]   = 1'($urandom_range(0, 1));
          p_both[p] = p_wr[p] && ($urandom_range(0, 3) == 0);
        end
      end
      r0_address = p_addr[0]; r0_data_in = p_data[0]; r0_data_size = p_size[0];
      r0_write_req = pend[0] && p_wr[0];
      r0_read_req  = pend[0] && (!p_wr[0] || p_both[0]);
      r1_address = p_addr[1]; r1_data_in = p_data[1]; r1_data_size = p_size[1];
      r1_write_req = pend[1] && p_wr[1];
      r1_read_req  = pend[1] && (!p_wr[1] || p_both[1]);
      @(negedge clk);

      ad_ack = mem_read_ack || mem_write_ack;
      n_vec++;
      if ({r0_txn_cnt, r1_txn_cnt} !== {4'(exp_cnt[0]), 4'(exp_cnt[1])}) begin
        n_err++; $display("FAIL %s_cnt: got %0d %0d expected %0d %0d", name, r0_txn_cnt, r1_txn_cnt, exp_cnt[0], exp_cnt[1]);
      end
      exp_busy = prev_ack ? 1'b0 : (prev_busy ? 1'b1 : (pend[0] || pend[1]));
      n_vec++;
      if (arb_busy !== exp_busy) begin
        n_err++; $display("FAIL %s_busy: got %b expected %b (cycle %0d)", name, arb_busy, exp_busy, cyc);
      end
      if (exp_busy && !prev_busy) begin
        w = (pend[0] && pend[1]) ? (TB_FIXED ? 1'b1 : exp_rr) : pend[1];
        owner = w;
        n_grants++;
        n_vec++;
        if ({mem_address, mem_data_in, mem_data_size, mem_write_req, mem_read_req} !==
            {p_addr[w], p_data[w], p_size[w], p_wr[w], !p_wr[w]}) begin
          n_err++; $display("FAIL %s_grant: got %h %h %b w%b r%b expected port %0d %h %h %b w%b",
            name, mem_address, mem_data_in, mem_data_size, mem_write_req, mem_read_req,
            w, p_addr[w], p_data[w], p_size[w], p_wr[w]);
        end
        if (check_gap && n_grants > 1) begin
          n_vec++;
          if (dut_idle != 1) begin
            n_err++; $display("FAIL %s_gap: got %0d idle cycles expected 1", name, dut_idle);
          end
        end
        dut_idle = 0;
      end
      if (!arb_busy) dut_idle++;
      if (exp_busy && !ad_ack) begin
        n_vec++;
        if ({mem_address, mem_write_req, mem_read_req} !== {p_addr[owner], p_wr[owner], !p_wr[owner]}) begin
          n_err++; $display("FAIL %s_hold: got %h w%b r%b expected %h w%b", name,
            mem_address, mem_write_req, mem_read_req, p_addr[owner], p_wr[owner]);
        end
      end
      if (exp_busy && ad_ack) begin
        exp_acks = owner ? {2'b00, !p_wr[1], p_wr[1]} : {!p_wr[0], p_wr[0], 2'b00};
        exp_d[0] = '0; exp_d[1] = '0;
        if (!p_wr[owner]) exp_d[owner] = p_addr[owner] ^ RD_KEY;
        n_vec++;
        if ({r0_read_ack, r0_write_ack, r1_read_ack, r1_write_ack, mem_read_req, mem_write_req} !== {exp_acks, 2'b00}) begin
          n_err++; $display("FAIL %s_acks: got %b expected %b", name,
            {r0_read_ack, r0_write_ack, r1_read_ack, r1_write_ack, mem_read_req, mem_write_req}, {exp_acks, 2'b00});
        end
        n_vec++;
        if ({r0_data_out, r1_data_out} !== {exp_d[0], exp_d[1]}) begin
          n_err++; $display("FAIL %s_rdata: got %h %h expected %h %h", name, r0_data_out, r1_data_out, exp_d[0], exp_d[1]);
        end
        if (exp_cnt[owner] < CNT_MAX) exp_cnt[owner]++;
        exp_rr = ~owner;
        pend[owner] = 1'b0;
        done++;
      end
      if (!exp_busy) begin
        n_vec++;
        if ({r0_read_ack, r0_write_ack, r1_read_ack, r1_write_ack} !== 4'b0000) begin
          n_err++; $display("FAIL %s_idle_ack: got %b expected 0000", name, {r0_read_ack, r0_write_ack, r1_read_ack, r1_write_ack});
        end
      end
      prev_ack  = exp_busy && ad_ack;
      prev_busy = exp_busy;
    end
    @(negedge clk);
    n_vec++;
    if (done != n_txn || {r0_txn_cnt, r1_txn_cnt} !== {4'(exp_cnt[0]), 4'(exp_cnt[1])}) begin
      n_err++; $display("FAIL %s_end: got %0d txns cnt %0d %0d expected %0d txns cnt %0d %0d",
        name, done, r0_txn_cnt, r1_txn_cnt, n_txn, exp_cnt[0], exp_cnt[1]);
    end
    drop_all();
    $display("%s: %0d transactions, counts %0d/%0d", name, done, r0_txn_cnt, r1_txn_cnt);
  endtask

  task automatic test_contention();
    do_reset();
    run_traffic("contention", 20, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    do_reset();
    run_traffic("random", 40, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    run_traffic("saturation", 34, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit any_ack = 1'b0;
    do_reset();
    ad_lat = 8;
    r0_address = 32'h40; r0_data_size = 2'b10; r0_read_req = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (arb_busy !== 1'b1) begin
      n_err++; $display("FAIL rstmid_busy: got %b expected 1", arb_busy);
    end
    reset = 1'b1;
    r0_read_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({arb_busy, mem_read_req, mem_write_req, mem_address, r0_read_ack, r0_data_out, r0_txn_cnt, r1_txn_cnt} !== '0) begin
      n_err++; $display("FAIL rstmid_clear: got busy %b rq %b addr %h ack %b cnt %0d/%0d expected all 0",
        arb_busy, mem_read_req, mem_address, r0_read_ack, r0_txn_cnt, r1_txn_cnt);
    end
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (r0_read_ack || r0_write_ack || r1_read_ack || r1_write_ack) any_ack = 1'b1;
    end
    n_vec++;
    if (any_ack) begin
      n_err++; $display("FAIL rstmid_no_ack: got ack expected none");
    end
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    n_vec++;
    if ({mem_read_ack, r0_read_ack, r1_read_ack, r0_data_out, r1_data_out} !== {3'b100, 64'd0}) begin
      n_err++; $display("FAIL stray_ack: got adapter %b ports %b%b data %h %h expected adapter 1 ports 00 data 0",
        mem_read_ack, r0_read_ack, r1_read_ack, r0_data_out, r1_data_out);
    end
    @(negedge clk);
    n_vec++;
    if ({r0_txn_cnt, r1_txn_cnt, arb_busy} !== 9'd0) begin
      n_err++; $display("FAIL stray_cnt: got %0d %0d busy %b expected 0 0 busy 0", r0_txn_cnt, r1_txn_cnt, arb_busy);
    end
    $display("reset_mid: abandoned transaction and stray ack checked");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_rw_both();
    test_stability();
    test_contention();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dti_mem_arbiter
